// File: rtl/ret_shadow_ctrl.sv
// Return-address shadow stack: records link-setting calls, checks returns.
// Ports: call/ret strobes in, debug read port, depth/overflow/violation/crash out.
module ret_shadow_ctrl #(
    parameter int DEPTH = 16,
    parameter int VLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       call_valid_i,
    input  logic [VLEN-1:0]            call_ret_addr_i,
    input  logic                       ret_valid_i,
    input  logic [VLEN-1:0]            ret_target_i,
    input  logic                       en_crash_i,
    input  logic                       clr_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_index_i,
    output logic [VLEN-1:0]            rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       overflow_o,
    output logic                       violation_o,
    output logic [CNT_W-1:0]           violation_cnt_o,
    output logic                       crash_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);
    localparam logic [IW-1:0]    ONE_I = IW'(1);
    localparam logic [DW-1:0]    ONE_D = DW'(1);
    localparam logic [DW-1:0]    FULL  = DW'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic {
        MONITOR = 1'b0,
        CRASH   = 1'b1
    } state_t;

    state_t          state;
    logic [VLEN-1:0] mem [DEPTH];
    logic [IW-1:0]   tp;
    logic [DW-1:0]   cnt;
    logic            ovf;
    logic            vio;
    logic [CNT_W-1:0] vcnt;

    logic          active;
    logic          empty;
    logic          do_pop;
    logic          wr_en;
    logic          viol;
    logic          set_ovf;
    logic [IW-1:0] tp_pop;
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] tp_nxt;
    logic [DW-1:0] cnt_pop;
    logic [DW-1:0] cnt_nxt;
    logic [IW-1:0] rd_ptr;

    // Pop is resolved first; a same-cycle push lands at the post-pop top.
    always_comb begin
        active  = (state == MONITOR) && !clr_i;
        empty   = (cnt == '0);
        do_pop  = active && ret_valid_i && !empty;
        // Empty with lost history (overflowed) is not a violation.
        viol    = active && ret_valid_i &&
                  (empty ? !ovf : (mem[tp] != ret_target_i));
        tp_pop  = do_pop ? tp - ONE_I : tp;
        cnt_pop = do_pop ? cnt - ONE_D : cnt;
        wr_en   = active && call_valid_i;
        wr_ptr  = tp_pop + ONE_I;
        tp_nxt  = wr_en ? wr_ptr : tp_pop;
        cnt_nxt = cnt_pop;
        set_ovf = 1'b0;
        if (wr_en) begin
            if (cnt_pop == FULL) begin
                set_ovf = 1'b1;
            end else begin
                cnt_nxt = cnt_pop + ONE_D;
            end
        end
    end

    always_comb begin
        rd_ptr    = tp - rd_index_i;
        rd_data_o = '0;
        if (DW'(rd_index_i) < cnt) begin
            rd_data_o = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= call_ret_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= MONITOR;
            tp    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            vio   <= 1'b0;
            vcnt  <= '0;
        end else if (clr_i) begin
            state <= MONITOR;
            tp    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            vio   <= 1'b0;
            vcnt  <= '0;
        end else begin
            tp  <= tp_nxt;
            cnt <= cnt_nxt;
            vio <= viol;
            if (set_ovf) begin
                ovf <= 1'b1;
            end
            if (viol && (vcnt != '1)) begin
                vcnt <= vcnt + ONE_C;
            end
            unique case (state)
                MONITOR: if (viol && en_crash_i) state <= CRASH;
                CRASH:   state <= CRASH;
                default: state <= MONITOR;
            endcase
        end
    end

    assign depth_o         = cnt;
    assign overflow_o      = ovf;
    assign violation_o     = vio;
    assign violation_cnt_o = vcnt;
    assign crash_o         = (state == CRASH);

endmodule
